// File: rtl/fx_pkg.sv
// rtl/fx_pkg.sv - shared effect codes, default geometry and sizing helpers for frame_reader_fx
package fx_pkg;

  typedef enum logic [2:0] {
    FX_PASS   = 3'd0,
    FX_INVERT = 3'd1,
    FX_GREY   = 3'd2,
    FX_THRESH = 3'd3,
    FX_POSTER = 3'd4
  } fx_mode_t;

  localparam int DEF_PIX_W     = 4;
  localparam int DEF_CW        = 10;
  localparam int DEF_SCR_W     = 640;
  localparam int DEF_SCR_H     = 480;
  localparam int DEF_FB_W      = 320;
  localparam int DEF_FB_H      = 240;
  localparam int DEF_DS_SH     = 1;
  localparam int DEF_ZOOM_MAX  = 3;
  localparam int DEF_BRAM_LAT  = 2;
  localparam int DEF_THRESH    = 8;
  localparam int DEF_POST_BITS = 2;

  function automatic int fb_aw(input int w, input int h);
    return $clog2(w * h);
  endfunction

  function automatic int msb_pos(input int v);
    int p;
    p = 0;
    for (int i = 0; i < 31; i++) begin
      if (v[i]) p = i;
    end
    return p;
  endfunction

  // True when v is 2^a or 2^a + 2^b, so the row multiply can be two shifts.
  function automatic bit is_two_pow_sum(input int v);
    int rem;
    rem = v - (1 << msb_pos(v));
    return (rem == 0) || (rem == (1 << msb_pos(rem)));
  endfunction

endpackage

// File: rtl/pixel_fx_unit.sv
// rtl/pixel_fx_unit.sv - per-pixel colour effect on BRAM read data with one output register
module pixel_fx_unit
  import fx_pkg::*;
#(
  parameter int PIX_W     = DEF_PIX_W,
  parameter int THRESH    = DEF_THRESH,
  parameter int POST_BITS = DEF_POST_BITS
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [2:0]         i_mode,
  input  logic [3*PIX_W-1:0] i_data,
  input  logic               i_de,
  output logic [PIX_W-1:0]   o_red,
  output logic [PIX_W-1:0]   o_green,
  output logic [PIX_W-1:0]   o_blue
);

  localparam logic [PIX_W-1:0] MAXV      = '1;
  localparam logic [PIX_W-1:0] POST_MASK = ~PIX_W'((1 << (PIX_W - POST_BITS)) - 1);

  logic [PIX_W-1:0] w_r, w_g, w_b;
  logic [PIX_W+1:0] w_sum;
  logic [PIX_W-1:0] w_grey, w_thr;
  logic [PIX_W-1:0] w_or, w_og, w_ob;

  always_comb begin
    w_r    = i_data[3*PIX_W-1 -: PIX_W];
    w_g    = i_data[2*PIX_W-1 -: PIX_W];
    w_b    = i_data[PIX_W-1:0];
    w_sum  = (PIX_W+2)'(w_r) + (PIX_W+2)'(w_g) + (PIX_W+2)'(w_b);
    w_grey = w_sum[PIX_W+1:2];
    w_thr  = (w_grey >= PIX_W'(THRESH)) ? MAXV : '0;
    w_or   = w_r;
    w_og   = w_g;
    w_ob   = w_b;
    // Unknown codes fall through to the pass-through defaults above.
    case (i_mode)
      FX_INVERT: begin
        w_or = MAXV - w_r;
        w_og = MAXV - w_g;
        w_ob = MAXV - w_b;
      end
      FX_GREY: begin
        w_or = w_grey;
        w_og = w_grey;
        w_ob = w_grey;
      end
      FX_THRESH: begin
        w_or = w_thr;
        w_og = w_thr;
        w_ob = w_thr;
      end
      FX_POSTER: begin
        w_or = w_r & POST_MASK;
        w_og = w_g & POST_MASK;
        w_ob = w_b & POST_MASK;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || !i_de) begin
      o_red   <= '0;
      o_green <= '0;
      o_blue  <= '0;
    end else begin
      o_red   <= w_or;
      o_green <= w_og;
      o_blue  <= w_ob;
    end
  end

endmodule

// File: rtl/frame_reader_fx.sv
// rtl/frame_reader_fx.sv - raster to framebuffer address generator with centre zoom, effects and sync delay
module frame_reader_fx
  import fx_pkg::*;
#(
  parameter int PIX_W     = DEF_PIX_W,
  parameter int CW        = DEF_CW,
  parameter int SCR_W     = DEF_SCR_W,
  parameter int SCR_H     = DEF_SCR_H,
  parameter int FB_W      = DEF_FB_W,
  parameter int FB_H      = DEF_FB_H,
  parameter int DS_SH     = DEF_DS_SH,
  parameter int ZOOM_MAX  = DEF_ZOOM_MAX,
  parameter int BRAM_LAT  = DEF_BRAM_LAT,
  parameter int THRESH    = DEF_THRESH,
  parameter int POST_BITS = DEF_POST_BITS,
  localparam int AW       = fb_aw(FB_W, FB_H)
) (
  input  logic               pixel_clk,
  input  logic               reset,
  input  logic [CW-1:0]      draw_x,
  input  logic [CW-1:0]      draw_y,
  input  logic               hs_in,
  input  logic               vs_in,
  input  logic               de_in,
  input  logic [2:0]         mode_sel,
  input  logic [1:0]         zoom_sh,
  output logic [AW-1:0]      rd_addr,
  input  logic [3*PIX_W-1:0] rd_data,
  output logic [PIX_W-1:0]   red,
  output logic [PIX_W-1:0]   green,
  output logic [PIX_W-1:0]   blue,
  output logic               hs_out,
  output logic               vs_out,
  output logic               de_out
);

  localparam int SW = CW + 2;
  localparam int L  = 3 + BRAM_LAT + 1;
  localparam logic signed [SW-1:0] HALF_W = SW'(SCR_W / 2);
  localparam logic signed [SW-1:0] HALF_H = SW'(SCR_H / 2);
  localparam logic signed [SW-1:0] MAX_X  = SW'(SCR_W - 1);
  localparam logic signed [SW-1:0] MAX_Y  = SW'(SCR_H - 1);

  logic [2:0]    r_mode;
  logic [1:0]    r_zoom;
  logic [2:0]    r_mode_p [L-1];
  logic [2:0]    r_sync   [L];
  logic [CW-1:0] r_xw, r_yw;
  logic [AW-1:0] r_fx, r_p_hi, r_p_lo;

  logic                 w_frame_start;
  logic [1:0]           w_zoom_req, w_zoom;
  logic [2:0]           w_mode;
  logic signed [SW-1:0] w_dx, w_dy, w_xw, w_yw, w_xc, w_yc;
  logic [CW-1:0]        w_fy;

  // The frame's first pixel already uses the values it loads.
  always_comb begin
    w_frame_start = de_in && (draw_x == '0) && (draw_y == '0);
    w_zoom_req    = (int'(zoom_sh) > ZOOM_MAX) ? 2'(ZOOM_MAX) : zoom_sh;
    w_zoom        = w_frame_start ? w_zoom_req : r_zoom;
    w_mode        = w_frame_start ? mode_sel : r_mode;
    w_dx          = $signed({2'b00, draw_x}) - HALF_W;
    w_dy          = $signed({2'b00, draw_y}) - HALF_H;
    w_xw          = (w_dx >>> w_zoom) + HALF_W;
    w_yw          = (w_dy >>> w_zoom) + HALF_H;
    w_xc          = w_xw;
    w_yc          = w_yw;
    if (w_xw < 0)          w_xc = '0;
    else if (w_xw > MAX_X) w_xc = MAX_X;
    if (w_yw < 0)          w_yc = '0;
    else if (w_yw > MAX_Y) w_yc = MAX_Y;
    w_fy          = r_yw >> DS_SH;
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      r_mode <= FX_PASS;
      r_zoom <= '0;
      r_xw   <= '0;
      r_yw   <= '0;
      r_fx   <= '0;
      for (int i = 0; i < L; i++)   r_sync[i]   <= '0;
      for (int i = 0; i < L-1; i++) r_mode_p[i] <= '0;
    end else begin
      if (w_frame_start) begin
        r_mode <= mode_sel;
        r_zoom <= w_zoom_req;
      end
      r_xw        <= CW'(w_xc);
      r_yw        <= CW'(w_yc);
      r_fx        <= AW'(r_xw >> DS_SH);
      r_sync[0]   <= {hs_in, vs_in, de_in};
      r_mode_p[0] <= w_mode;
      for (int i = 1; i < L; i++)   r_sync[i]   <= r_sync[i-1];
      for (int i = 1; i < L-1; i++) r_mode_p[i] <= r_mode_p[i-1];
    end
  end

  generate
    if (is_two_pow_sum(FB_W)) begin : g_shadd
      localparam int HI  = msb_pos(FB_W);
      localparam int REM = FB_W - (1 << HI);
      always_ff @(posedge pixel_clk) begin
        if (reset) begin
          r_p_hi <= '0;
          r_p_lo <= '0;
        end else begin
          r_p_hi <= AW'(w_fy) << HI;
          r_p_lo <= (REM == 0) ? '0 : (AW'(w_fy) << msb_pos(REM));
        end
      end
    end else begin : g_mul
      always_ff @(posedge pixel_clk) begin
        if (reset) begin
          r_p_hi <= '0;
          r_p_lo <= '0;
        end else begin
          r_p_hi <= AW'(int'(w_fy) * FB_W);
          r_p_lo <= '0;
        end
      end
    end
  endgenerate

  always_ff @(posedge pixel_clk) begin
    if (reset) rd_addr <= '0;
    else       rd_addr <= r_p_hi + r_p_lo + r_fx;
  end

  pixel_fx_unit #(
    .PIX_W     (PIX_W),
    .THRESH    (THRESH),
    .POST_BITS (POST_BITS)
  ) u_fx (
    .i_clk   (pixel_clk),
    .i_reset (reset),
    .i_mode  (r_mode_p[L-2]),
    .i_data  (rd_data),
    .i_de    (r_sync[L-2][0]),
    .o_red   (red),
    .o_green (green),
    .o_blue  (blue)
  );

  assign hs_out = r_sync[L-1][2];
  assign vs_out = r_sync[L-1][1];
  assign de_out = r_sync[L-1][0];

endmodule

// File: tb/tb_frame_reader_fx.sv
// tb/tb_frame_reader_fx.sv - directed self-checking bench for frame_reader_fx
module tb_frame_reader_fx;
  import fx_pkg::*;

  logic        pixel_clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  draw_x, draw_y;
  logic        hs_in, vs_in, de_in;
  logic [2:0]  mode_sel;
  logic [1:0]  zoom_sh;
  logic [16:0] rd_addr;
  logic [11:0] rd_data;
  logic [3:0]  red, green, blue;
  logic        hs_out, vs_out, de_out;

  logic        force_en = 1'b0;
  logic [11:0] force_val = 12'h000;
  logic [11:0] r_b1, r_b2;

  int checks = 0;
  int failures = 0;

  logic [16:0] obs_addr;
  logic [11:0] obs_rgb;
  logic [2:0]  obs_early, obs_sync;

  frame_reader_fx dut (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .draw_x    (draw_x),
    .draw_y    (draw_y),
    .hs_in     (hs_in),
    .vs_in     (vs_in),
    .de_in     (de_in),
    .mode_sel  (mode_sel),
    .zoom_sh   (zoom_sh),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .hs_out    (hs_out),
    .vs_out    (vs_out),
    .de_out    (de_out)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Two-cycle BRAM returning the low 12 address bits, with a constant override.
  always @(posedge pixel_clk) begin
    r_b1 <= rd_addr[11:0];
    r_b2 <= r_b1;
  end
  assign rd_data = force_en ? force_val : r_b2;

  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic idle();
    draw_x = 10'd700;
    draw_y = 10'd500;
    de_in  = 1'b0;
    hs_in  = 1'b0;
    vs_in  = 1'b0;
  endtask

  // One pixel followed by blanking; captures address, pre-latency syncs and output.
  task automatic send_pix(input logic [9:0] x, input logic [9:0] y, input logic de);
    draw_x = x;
    draw_y = y;
    de_in  = de;
    hs_in  = 1'b1;
    vs_in  = 1'b1;
    step();
    idle();
    step();
    step();
    obs_addr = rd_addr;
    step();
    step();
    obs_early = {hs_out, vs_out, de_out};
    step();
    obs_rgb  = {red, green, blue};
    obs_sync = {hs_out, vs_out, de_out};
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    mode_sel = 3'd0;
    zoom_sh  = 2'd0;
    idle();
    repeat (4) step();
    checks++;
    if (rd_addr !== 17'd0) begin
      failures++;
      $display("FAIL reset_addr got=%0d want=0", rd_addr);
    end
    checks++;
    if ({red, green, blue} !== 12'h000) begin
      failures++;
      $display("FAIL reset_rgb got=%h want=000", {red, green, blue});
    end
    checks++;
    if ({hs_out, vs_out, de_out} !== 3'b000) begin
      failures++;
      $display("FAIL reset_sync got=%b want=000", {hs_out, vs_out, de_out});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_pass();
    logic [9:0]  xs [4] = '{10'd0, 10'd639, 10'd1, 10'd2};
    logic [9:0]  ys [4] = '{10'd0, 10'd479, 10'd0, 10'd2};
    logic [16:0] ea [4] = '{17'd0, 17'd76799, 17'd0, 17'd321};
    logic [11:0] er [4] = '{12'h000, 12'hBFF, 12'h000, 12'h141};
    mode_sel = FX_PASS;
    zoom_sh  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      send_pix(xs[i], ys[i], 1'b1);
      checks++;
      if (obs_addr !== ea[i]) begin
        failures++;
        $display("FAIL pass_addr[%0d] got=%0d want=%0d", i, obs_addr, ea[i]);
      end
      checks++;
      if (obs_rgb !== er[i]) begin
        failures++;
        $display("FAIL pass_rgb[%0d] got=%h want=%h", i, obs_rgb, er[i]);
      end
      checks++;
      if (obs_early !== 3'b000 || obs_sync !== 3'b111) begin
        failures++;
        $display("FAIL pass_latency[%0d] early=%b want=000 at6=%b want=111", i, obs_early, obs_sync);
      end
    end
  endtask

  task automatic test_effects();
    logic [2:0]  ms [6] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd7};
    logic [11:0] vs [6] = '{12'h123, 12'hF30, 12'hF30, 12'hFFF, 12'hFA5, 12'h123};
    logic [11:0] es [6] = '{12'hEDC, 12'h444, 12'h000, 12'hFFF, 12'hC84, 12'h123};
    force_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mode_sel  = ms[i];
      force_val = vs[i];
      send_pix(10'd0, 10'd0, 1'b1);
      checks++;
      if (obs_rgb !== es[i]) begin
        failures++;
        $display("FAIL effect[%0d] mode=%0d data=%h got=%h want=%h", i, ms[i], vs[i], obs_rgb, es[i]);
      end
    end
    force_en = 1'b0;
    mode_sel = FX_PASS;
  endtask

  task automatic test_frame_latch();
    mode_sel = FX_PASS;
    send_pix(10'd0, 10'd0, 1'b1);
    mode_sel = FX_INVERT;
    send_pix(10'd100, 10'd50, 1'b1);
    checks++;
    if (obs_addr !== 17'd8050) begin
      failures++;
      $display("FAIL latch_addr got=%0d want=8050", obs_addr);
    end
    checks++;
    if (obs_rgb !== 12'hF72) begin
      failures++;
      $display("FAIL latch_midframe got=%h want=F72", obs_rgb);
    end
    send_pix(10'd0, 10'd0, 1'b1);
    checks++;
    if (obs_rgb !== 12'hFFF) begin
      failures++;
      $display("FAIL latch_newframe got=%h want=FFF", obs_rgb);
    end
    mode_sel = FX_PASS;
    send_pix(10'd0, 10'd0, 1'b1);
  endtask

  task automatic test_zoom();
    logic [1:0]  zs [7] = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
    logic [9:0]  xs [7] = '{10'd0, 10'd639, 10'd0, 10'd639, 10'd1023, 10'd0, 10'd1023};
    logic [9:0]  ys [7] = '{10'd0, 10'd479, 10'd0, 10'd479, 10'd1023, 10'd0, 10'd1023};
    logic [16:0] ea [7] = '{17'd19280, 17'd57519, 17'd33740, 17'd43059, 17'd53963, 17'd0, 17'd76799};
    mode_sel = FX_PASS;
    for (int i = 0; i < 7; i++) begin
      zoom_sh = zs[i];
      send_pix(xs[i], ys[i], 1'b1);
      checks++;
      if (obs_addr !== ea[i]) begin
        failures++;
        $display("FAIL zoom_addr[%0d] zoom=%0d got=%0d want=%0d", i, zs[i], obs_addr, ea[i]);
      end
    end
    checks++;
    if (obs_rgb !== 12'hBFF) begin
      failures++;
      $display("FAIL zoom_clamp_rgb got=%h want=BFF", obs_rgb);
    end
    zoom_sh = 2'd0;
  endtask

  task automatic test_blank();
    force_en  = 1'b1;
    force_val = 12'hFFF;
    send_pix(10'd10, 10'd10, 1'b0);
    checks++;
    if (obs_rgb !== 12'h000) begin
      failures++;
      $display("FAIL blank_rgb got=%h want=000", obs_rgb);
    end
    checks++;
    if (obs_sync !== 3'b110) begin
      failures++;
      $display("FAIL blank_sync got=%b want=110", obs_sync);
    end
    force_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic early_bad;
    force_en  = 1'b1;
    force_val = 12'hFFF;
    mode_sel  = FX_INVERT;
    send_pix(10'd0, 10'd0, 1'b1);
    checks++;
    if (obs_rgb !== 12'h000) begin
      failures++;
      $display("FAIL rstmid_invert got=%h want=000", obs_rgb);
    end
    draw_x = 10'd5;
    draw_y = 10'd5;
    de_in  = 1'b1;
    repeat (6) step();
    checks++;
    if (de_out !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_stream_de got=%b want=1", de_out);
    end
    reset = 1'b1;
    step();
    checks++;
    if (de_out !== 1'b0 || {red, green, blue} !== 12'h000) begin
      failures++;
      $display("FAIL rstmid_clear de=%b rgb=%h want de=0 rgb=000", de_out, {red, green, blue});
    end
    reset = 1'b0;
    early_bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (de_out !== 1'b0) early_bad = 1'b1;
    end
    checks++;
    if (early_bad !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_early_de got=1 want=0 before latency");
    end
    step();
    checks++;
    if (de_out !== 1'b1 || {red, green, blue} !== 12'hFFF) begin
      failures++;
      $display("FAIL rstmid_first de=%b rgb=%h want de=1 rgb=FFF", de_out, {red, green, blue});
    end
    idle();
    force_en = 1'b0;
    mode_sel = FX_PASS;
    repeat (8) step();
  endtask

  initial begin
    test_reset();
    test_pass();
    test_effects();
    test_frame_latch();
    test_zoom();
    test_blank();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
